// File: rtl/multi_mode_register.sv
// multi_mode_register: WIDTH-bit register with parallel load, increment,
// decrement, shifts and rotate. It keeps a registered carry/borrow/shift-out
// flag and a combinational zero flag. Used as a PC, accumulator or shifter.
module multi_mode_register #(
    parameter int                 WIDTH       = 11,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_INC  = 3'b010,
        MODE_DEC  = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ZERO = 3'b111
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    // Next-state decode. enable gates the whole decode, so an unknown mode
    // while disabled can never reach the state.
    always_comb begin
        // NOTE: defaults first mean every path assigns both outputs, so no latch is inferred.
        q_next     = Q;
        carry_next = carry;
        if (enable) begin
            case (mode_t'(mode))
                MODE_HOLD: begin
                    q_next     = Q;
                    carry_next = carry;
                end
                MODE_LOAD: begin
                    q_next     = in;
                    carry_next = 1'b0;
                end
                MODE_INC: begin
                    // The extra top bit of the WIDTH+1 sum is the carry out.
                    {carry_next, q_next} = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
                end
                MODE_DEC: begin
                    // Decrementing 0 sets the extra top bit, which is the borrow.
                    {carry_next, q_next} = {1'b0, Q} - {{WIDTH{1'b0}}, 1'b1};
                end
                MODE_SHL: begin
                    q_next     = {Q[WIDTH-2:0], serial_in};
                    carry_next = Q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next     = {serial_in, Q[WIDTH-1:1]};
                    carry_next = Q[0];
                end
                MODE_ROL: begin
                    q_next     = {Q[WIDTH-2:0], Q[WIDTH-1]};
                    carry_next = Q[WIDTH-1];
                end
                MODE_ZERO: begin
                    q_next     = '0;
                    carry_next = 1'b0;
                end
                default: begin
                    q_next     = Q;
                    carry_next = carry;
                end
            endcase
        end
    end

    // State register. The synchronous clear overrides enable and mode.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values together.
        if (clear) begin
            Q     <= RESET_VALUE;
            carry <= 1'b0;
        end else begin
            Q     <= q_next;
            carry <= carry_next;
        end
    end

    // The zero flag follows Q in the same cycle.
    assign zero = (Q == '0);

endmodule

// File: tb/tb_multi_mode_register.sv
// Testbench for multi_mode_register. Three instances share one stimulus
// stream: 11-bit with reset value 0, 11-bit with reset value 0x100, and
// 4-bit. A behavioural model pushes expected results into a scoreboard
// queue. A monitor on the falling edge pops entries and compares them.
module tb_multi_mode_register;

    logic        CLK = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [10:0] din = '0;
    logic        serial_in = 1'b0;

    logic [10:0] q_a, q_b;
    logic [3:0]  q_c;
    logic        carry_a, carry_b, carry_c;
    logic        zero_a, zero_b, zero_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          inst;
        int unsigned q;
        bit          c;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // Model state per instance.
    int          widths[3] = '{11, 11, 4};
    int unsigned rvals[3]  = '{32'h0, 32'h100, 32'h0};
    int unsigned mq[3];
    bit          mc[3];
    bit          known[3] = '{1'b0, 1'b0, 1'b0};

    always #5 CLK = ~CLK;

    multi_mode_register #(.WIDTH(11), .RESET_VALUE(11'h000)) dut_a (
        .CLK(CLK), .clear(clear), .enable(enable), .mode(mode), .in(din),
        .serial_in(serial_in), .Q(q_a), .carry(carry_a), .zero(zero_a)
    );

    multi_mode_register #(.WIDTH(11), .RESET_VALUE(11'h100)) dut_b (
        .CLK(CLK), .clear(clear), .enable(enable), .mode(mode), .in(din),
        .serial_in(serial_in), .Q(q_b), .carry(carry_b), .zero(zero_b)
    );

    multi_mode_register #(.WIDTH(4), .RESET_VALUE(4'h0)) dut_c (
        .CLK(CLK), .clear(clear), .enable(enable), .mode(mode), .in(din[3:0]),
        .serial_in(serial_in), .Q(q_c), .carry(carry_c), .zero(zero_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then advance the model at the sampling edge.
    task automatic apply(input string tag, input bit clr, input bit en,
                         input logic [2:0] md, input logic [10:0] d, input bit si);
        @(negedge CLK);
        #1;
        clear     = clr;
        enable    = en;
        mode      = md;
        din       = d;
        serial_in = si;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            int          w;
            int unsigned mask, msb;
            exp_t        e;
            w    = widths[i];
            mask = (32'd1 << w) - 1;
            msb  = (mq[i] >> (w - 1)) & 1;
            if (clr) begin
                mq[i]    = rvals[i];
                mc[i]    = 1'b0;
                known[i] = 1'b1;
            end else if (en && known[i]) begin
                case (md)
                    3'd1: begin mq[i] = d & mask; mc[i] = 1'b0; end
                    3'd2: begin
                        mc[i] = (mq[i] == mask);
                        mq[i] = (mq[i] + 1) % (mask + 1);
                    end
                    3'd3: begin
                        mc[i] = (mq[i] == 0);
                        mq[i] = (mq[i] == 0) ? mask : mq[i] - 1;
                    end
                    3'd4: begin mc[i] = msb[0]; mq[i] = ((mq[i] * 2) + si) & mask; end
                    3'd5: begin mc[i] = mq[i][0]; mq[i] = (mq[i] / 2) + (si ? (mask + 1) / 2 : 0); end
                    3'd6: begin mc[i] = msb[0]; mq[i] = ((mq[i] * 2) + msb) & mask; end
                    3'd7: begin mq[i] = 0; mc[i] = 1'b0; end
                    default: ;
                endcase
            end
            if (known[i]) begin
                e.inst = i;
                e.q    = mq[i];
                e.c    = mc[i];
                e.tag  = tag;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: outputs are valid every cycle after the first clear.
    initial begin
        forever begin
            @(negedge CLK);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [31:0] aq;
                logic        ac, az;
                e = sb.pop_front();
                case (e.inst)
                    0:       begin aq = {21'd0, q_a}; ac = carry_a; az = zero_a; end
                    1:       begin aq = {21'd0, q_b}; ac = carry_b; az = zero_b; end
                    default: begin aq = {28'd0, q_c}; ac = carry_c; az = zero_c; end
                endcase
                check($sformatf("%s[%0d].Q", e.tag, e.inst), aq, e.q);
                check($sformatf("%s[%0d].carry", e.tag, e.inst), {31'd0, ac}, {31'd0, e.c});
                check($sformatf("%s[%0d].zero", e.tag, e.inst), {31'd0, az}, {31'd0, e.q == 0});
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Clear and hold.
        apply("clear", 1, 0, 3'b000, 11'h000, 0);
        apply("hold0", 0, 0, 3'b001, 11'h001, 0);
        apply("hold0", 0, 0, 3'b001, 11'h001, 0);
        // Load and enable gating, including an unknown mode while disabled.
        apply("load", 0, 1, 3'b001, 11'b10101010101, 0);
        apply("gate", 0, 0, 3'b001, 11'h7FF, 0);
        apply("gatex", 0, 0, 3'bxxx, 11'h7FF, 1);
        // Increment and decrement wrap.
        apply("ld7fe", 0, 1, 3'b001, 11'h7FE, 0);
        apply("inc1", 0, 1, 3'b010, 11'h000, 0);
        apply("inc2", 0, 1, 3'b010, 11'h000, 0);
        apply("holdc", 0, 1, 3'b000, 11'h123, 1);
        apply("dec", 0, 1, 3'b011, 11'h000, 0);
        // Shifts and rotate.
        apply("ld401", 0, 1, 3'b001, 11'b10000000001, 0);
        apply("shl", 0, 1, 3'b100, 11'h000, 0);
        apply("shr", 0, 1, 3'b101, 11'h000, 1);
        apply("rol", 0, 1, 3'b110, 11'h000, 0);
        // Clear mid-run beats a simultaneous load, then ZERO.
        apply("clr", 1, 0, 3'b000, 11'h000, 0);
        for (int k = 0; k < 3; k++) apply("incrun", 0, 1, 3'b010, 11'h000, 0);
        apply("clrprio", 1, 1, 3'b001, 11'h7FF, 0);
        apply("resume", 0, 1, 3'b010, 11'h000, 0);
        apply("zero", 0, 1, 3'b111, 11'h000, 0);
        // Narrow-width wrap and shift-right fill.
        apply("ld00f", 0, 1, 3'b001, 11'h00F, 0);
        apply("inc4", 0, 1, 3'b010, 11'h000, 0);
        apply("ld000", 0, 1, 3'b001, 11'h000, 0);
        apply("shr4", 0, 1, 3'b101, 11'h000, 1);
        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            apply("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 11'($urandom), 1'($urandom));
        end
        @(negedge CLK);
        @(negedge CLK);
        check("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
